// File: rtl/ctrlpop.sv
// ctrlpop: extract-min controller for the 8-bit min-heap held in a
// single-port 256x8 memory (1-indexed, root at address 1).
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous active-high reset
//   start    in   pop request, sampled only in IDLE
//   size     in   current element count from the size register
//   mdout    in   memory read data, combinational from maddr
//   sizedec  out  one-cycle pulse, size register decrements next edge
//   mwen     out  memory write enable
//   maddr    out  memory address
//   mdin     out  memory write data
//   dout     out  popped value, held until the next non-empty pop
//   done     out  one-cycle completion pulse

module ctrlpop (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] size,
   input  logic [7:0] mdout,
   output logic       sizedec,
   output logic       mwen,
   output logic [7:0] maddr,
   output logic [7:0] mdin,
   output logic [7:0] dout,
   output logic       done
);

   typedef enum logic [3:0] {
      IDLE  = 4'd0,
      INIT  = 4'd1,
      LAST  = 4'd2,
      LEFT  = 4'd3,
      RIGHT = 4'd4,
      COMP  = 4'd5,
      PLACE = 4'd6,
      DONE  = 4'd7
   } state_t;

   state_t     state;
   logic [7:0] n;
   logic [7:0] x;
   logic [7:0] idx;
   logic [7:0] cv;
   logic [7:0] cidx;

   // Child indices are formed 9 bits wide so 2*idx never wraps.
   logic [8:0] c;
   logic [8:0] rc;
   logic       left_ok;
   logic       right_ok;
   logic       right_wins;
   logic       move;

   assign c          = {idx, 1'b0};
   assign rc         = {1'b0, cidx} + 9'd1;
   assign left_ok    = c <= {1'b0, n};
   assign right_ok   = rc <= {1'b0, n};
   // Strict compare: on a tie the left child is kept.
   assign right_wins = right_ok && (mdout < cv);
   // Strict compare: a child equal to x ends the sift.
   assign move       = cv < x;

   // Memory reads are combinational, so the address must be a
   // function of the current state rather than a registered value.
   always_comb begin
      sizedec = 1'b0;
      mwen    = 1'b0;
      maddr   = 8'd0;
      mdin    = (state == COMP) ? cv : x;
      done    = 1'b0;
      unique case (state)
         INIT: begin
            maddr   = 8'd1;
            sizedec = 1'b1;
         end
         LAST: begin
            maddr = n + 8'd1;
         end
         LEFT: begin
            if (left_ok) begin
               maddr = c[7:0];
            end
         end
         RIGHT: begin
            maddr = rc[7:0];
         end
         COMP: begin
            if (move) begin
               mwen  = 1'b1;
               maddr = idx;
            end
         end
         PLACE: begin
            mwen  = 1'b1;
            maddr = idx;
         end
         DONE: begin
            done = 1'b1;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         n     <= 8'd0;
         x     <= 8'd0;
         idx   <= 8'd0;
         cv    <= 8'd0;
         cidx  <= 8'd0;
         dout  <= 8'd0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  // An empty pop skips straight to DONE untouched.
                  state <= (size == 8'd0) ? DONE : INIT;
               end
            end
            INIT: begin
               dout  <= mdout;
               n     <= size - 8'd1;
               idx   <= 8'd1;
               state <= LAST;
            end
            LAST: begin
               x     <= mdout;
               state <= (n == 8'd0) ? DONE : LEFT;
            end
            LEFT: begin
               if (left_ok) begin
                  cv    <= mdout;
                  cidx  <= c[7:0];
                  state <= RIGHT;
               end else begin
                  state <= PLACE;
               end
            end
            RIGHT: begin
               // Read beyond n is ignored via right_ok.
               if (right_wins) begin
                  cv   <= mdout;
                  cidx <= rc[7:0];
               end
               state <= COMP;
            end
            COMP: begin
               if (move) begin
                  idx   <= cidx;
                  state <= LEFT;
               end else begin
                  state <= PLACE;
               end
            end
            PLACE: begin
               state <= DONE;
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
